// File: rtl/card_dealer_pkg.sv
// card_dealer_pkg: deck constants, card value constants and dealer FSM states
package card_dealer_pkg;
  localparam int DECK_CARDS = 52;
  localparam int RANKS_PER_SUIT = 13;
  localparam int FACE_RANK = 10;
  localparam int FACE_VALUE = 10;
  typedef enum logic [2:0] {IDLE, SAMPLE, CHECK, SCAN, DONE} state_t;
endpackage

// File: rtl/card_dealer_decode.sv
// card_decode: combinational card id to suit/rank/blackjack value
module card_decode
  import card_dealer_pkg::*;
(
  input  logic [5:0] id,
  output logic [1:0] suit,
  output logic [3:0] rank,
  output logic [3:0] value
);
  assign suit = 2'(id / 6'(RANKS_PER_SUIT));
  assign rank = 4'(id % 6'(RANKS_PER_SUIT)) + 4'd1;
  assign value = rank >= 4'(FACE_RANK) ? 4'(FACE_VALUE) : rank;
endmodule

// File: rtl/card_dealer.sv
// card_dealer: draws cards without replacement using rejection sampling with a linear-scan fallback
module card_dealer
  import card_dealer_pkg::*;
#(
  parameter int DECK_SIZE = DECK_CARDS,
  parameter int MAX_RETRY = 16,
  parameter int RAND_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [RAND_W-1:0] rnd,
  input  logic              rnd_valid,
  output logic              rnd_req,
  input  logic              deal_req,
  input  logic              shuffle,
  output logic              card_valid,
  output logic [5:0]        card_id,
  output logic [1:0]        card_suit,
  output logic [3:0]        card_rank,
  output logic [3:0]        card_value,
  output logic [5:0]        cards_left,
  output logic              deck_empty,
  output logic              deal_err
);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [5:0] LAST = 6'(DECK_SIZE - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
  state_t state, state_nx;
  logic [DECK_SIZE-1:0] mask;
  logic [RAND_W-1:0] sample;
  logic [5:0] ptr, cand;
  logic [RW-1:0] retry;
  logic avail;
  logic [1:0] dec_suit;
  logic [3:0] dec_rank, dec_value;
  assign rnd_req = state == SAMPLE;
  assign card_valid = state == DONE;
  assign deck_empty = cards_left == '0;
  assign cand = state == SCAN ? ptr : 6'(sample);
  assign avail = cand <= LAST && !mask[cand];
  card_decode u_decode (.id(cand), .suit(dec_suit), .rank(dec_rank), .value(dec_value));
  // next-state: shuffle overrides everything and returns to IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = deal_req && !deck_empty ? SAMPLE : IDLE;
      SAMPLE:  state_nx = rnd_valid ? CHECK : SAMPLE;
      CHECK:   state_nx = avail ? DONE : retry == RETRY_LAST ? SCAN : SAMPLE;
      SCAN:    state_nx = avail ? DONE : SCAN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (shuffle) state_nx = IDLE;
  end
  // deck mask, counters, sample latch and card output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      mask <= '0;
      cards_left <= 6'(DECK_SIZE);
      retry <= '0;
      sample <= '0;
      ptr <= '0;
      deal_err <= 1'b0;
      card_id <= '0;
      card_suit <= '0;
      card_rank <= '0;
      card_value <= '0;
    end else if (shuffle) begin
      state <= IDLE;
      mask <= '0;
      cards_left <= 6'(DECK_SIZE);
      retry <= '0;
      deal_err <= 1'b0;
    end else begin
      state <= state_nx;
      deal_err <= state == IDLE && deal_req && deck_empty;
      if (state == IDLE && deal_req) retry <= '0;
      if (state == SAMPLE && rnd_valid) sample <= rnd;
      if (state == CHECK && !avail) begin
        retry <= retry + 1'b1;
        ptr <= cand <= LAST ? cand : cand - 6'(DECK_SIZE);
      end
      if (state == SCAN && !avail) ptr <= ptr == LAST ? '0 : ptr + 6'd1;
      if ((state == CHECK || state == SCAN) && avail) begin
        mask[cand] <= 1'b1;
        cards_left <= cards_left - 6'd1;
        card_id <= cand;
        card_suit <= dec_suit;
        card_rank <= dec_rank;
        card_value <= dec_value;
      end
    end
  end
endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: table vectors, random deals against a deck model, and shuffle/reset corner cases
module tb_card_dealer;
  logic clk = 0, reset_n = 0, rnd_valid = 0, deal_req = 0, shuffle = 0;
  logic [5:0] rnd = 0;
  logic rnd_req, card_valid, deck_empty, deal_err;
  logic [5:0] card_id, cards_left;
  logic [1:0] card_suit;
  logic [3:0] card_rank, card_value;
  card_dealer #(.MAX_RETRY(4)) dut (
    .clk(clk), .reset_n(reset_n), .rnd(rnd), .rnd_valid(rnd_valid), .rnd_req(rnd_req),
    .deal_req(deal_req), .shuffle(shuffle), .card_valid(card_valid), .card_id(card_id),
    .card_suit(card_suit), .card_rank(card_rank), .card_value(card_value),
    .cards_left(cards_left), .deck_empty(deck_empty), .deal_err(deal_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    int s0, s1, s2, s3;
    int id, suit, rank, value, used;
  } vec_t;
  vec_t tbl[10];
  int n_cmp = 0, n_bad = 0;
  bit dealt[52];
  int left_m = 52;
  logic [5:0] smp[4];
  int used = 0, last_lat = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 52; i++) dealt[i] = 0;
    left_m = 52;
  endtask
  // expected card: first fresh in-range sample among four, otherwise the next fresh card from the last sample folded into range
  function automatic int pick(output int nu);
    int p;
    for (int i = 0; i < 4; i++) begin
      nu = i + 1;
      if (smp[i] < 52 && !dealt[smp[i]]) return int'(smp[i]);
    end
    p = smp[3] < 52 ? int'(smp[3]) : int'(smp[3]) - 52;
    for (int k = 0; k < 52; k++) if (!dealt[(p + k) % 52]) return (p + k) % 52;
    return -1;
  endfunction
  task automatic run_deal(input bit gaps, output bit got);
    got = 0;
    used = 0;
    last_lat = 0;
    deal_req = 1;
    @(negedge clk);
    deal_req = 0;
    for (int c = 1; c < 300 && !got; c++) begin
      if (card_valid) begin
        got = 1;
        last_lat = c;
      end else begin
        rnd_valid = rnd_req && (!gaps || $urandom_range(0, 2) == 0);
        rnd = used < 4 ? smp[used] : 6'($urandom);
        if (rnd_valid) used++;
        @(negedge clk);
      end
    end
    rnd_valid = 0;
  endtask
  task automatic deal_check(input string tag, input bit gaps, input int eid, input int esuit,
                            input int erank, input int evalue, input int eused);
    bit got;
    run_deal(gaps, got);
    chk({tag, ":valid"}, int'(got), 1);
    if (got) begin
      chk({tag, ":fresh"}, card_id < 52 ? int'(dealt[card_id]) : 1, 0);
      chk({tag, ":id"}, int'(card_id), eid);
      chk({tag, ":suit"}, int'(card_suit), esuit);
      chk({tag, ":rank"}, int'(card_rank), erank);
      chk({tag, ":value"}, int'(card_value), evalue);
      chk({tag, ":samples"}, used, eused);
      chk({tag, ":left"}, int'(cards_left), left_m - 1);
      if (eid >= 0) dealt[eid] = 1;
      left_m--;
      @(negedge clk);
      chk({tag, ":pulse"}, int'(card_valid), 0);
      chk({tag, ":held"}, int'(card_id), eid);
    end
  endtask
  task automatic model_deal(input string tag, input bit gaps);
    int id, nu, r;
    id = pick(nu);
    r = id % 13 + 1;
    deal_check(tag, gaps, id, id / 13, r, r >= 10 ? 10 : r, nu);
  endtask
  task automatic set_smp(input int a, input int b, input int c, input int d);
    smp[0] = 6'(a); smp[1] = 6'(b); smp[2] = 6'(c); smp[3] = 6'(d);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{5, 0, 0, 0, 5, 0, 6, 6, 1};
    tbl[1] = '{60, 5, 12, 0, 12, 0, 13, 10, 3};
    tbl[2] = '{63, 63, 63, 63, 11, 0, 12, 10, 4};
    tbl[3] = '{63, 63, 63, 63, 13, 1, 1, 1, 4};
    tbl[4] = '{51, 0, 0, 0, 51, 3, 13, 10, 1};
    tbl[5] = '{62, 62, 62, 62, 10, 0, 11, 10, 4};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    tbl[7] = '{55, 56, 57, 51, 1, 0, 2, 2, 4};
    tbl[8] = '{26, 0, 0, 0, 26, 2, 1, 1, 1};
    tbl[9] = '{39, 0, 0, 0, 39, 3, 1, 1, 1};
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("rst:left", int'(cards_left), 52);
    chk("rst:empty", int'(deck_empty), 0);
    chk("rst:rnd_req", int'(rnd_req), 0);
    chk("rst:valid", int'(card_valid), 0);
    chk("rst:err", int'(deal_err), 0);
    chk("rst:id", int'(card_id), 0);
    chk("rst:rank", int'(card_rank), 0);
    chk("rst:value", int'(card_value), 0);
    for (int i = 0; i < 10; i++) begin
      set_smp(tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].s3);
      deal_check($sformatf("tbl%0d", i), 0, tbl[i].id, tbl[i].suit, tbl[i].rank, tbl[i].value, tbl[i].used);
      if (i == 0) chk("tbl0:latency", last_lat, 3);
    end
    shuffle = 1;
    @(negedge clk);
    shuffle = 0;
    model_reset();
    chk("shuf:left", int'(cards_left), 52);
    for (int n = 0; n < 52; n++) begin
      for (int i = 0; i < 4; i++) smp[i] = $urandom_range(0, 3) == 0 ? 6'($urandom_range(52, 63)) : 6'($urandom_range(0, 63));
      model_deal($sformatf("rnd%0d", n), 1);
    end
    chk("full:left", int'(cards_left), 0);
    chk("full:empty", int'(deck_empty), 1);
    deal_req = 1;
    @(negedge clk);
    deal_req = 0;
    chk("empty:err", int'(deal_err), 1);
    chk("empty:rnd_req", int'(rnd_req), 0);
    @(negedge clk);
    chk("empty:err_pulse", int'(deal_err), 0);
    begin
      int seen = 0;
      repeat (5) begin
        if (card_valid || rnd_req) seen++;
        @(negedge clk);
      end
      chk("empty:no_card", seen, 0);
    end
    shuffle = 1;
    @(negedge clk);
    shuffle = 0;
    model_reset();
    chk("reshuf:left", int'(cards_left), 52);
    chk("reshuf:empty", int'(deck_empty), 0);
    set_smp(20, 0, 0, 0);
    deal_check("pre_abort", 0, 20, 1, 8, 8, 1);
    deal_req = 1;
    @(negedge clk);
    deal_req = 0;
    chk("abort:in_sample", int'(rnd_req), 1);
    shuffle = 1;
    @(negedge clk);
    shuffle = 0;
    model_reset();
    chk("abort:rnd_req", int'(rnd_req), 0);
    chk("abort:left", int'(cards_left), 52);
    begin
      int seen = 0;
      repeat (5) begin
        rnd_valid = 1;
        rnd = 6'd7;
        if (card_valid || rnd_req || deal_err) seen++;
        @(negedge clk);
      end
      rnd_valid = 0;
      chk("abort:idle", seen, 0);
    end
    deal_req = 1;
    shuffle = 1;
    @(negedge clk);
    deal_req = 0;
    shuffle = 0;
    chk("shuf_deal:dropped", int'(rnd_req), 0);
    @(negedge clk);
    chk("shuf_deal:idle", int'(rnd_req), 0);
    set_smp(33, 0, 0, 0);
    deal_check("pre_reset", 1, 33, 2, 8, 8, 1);
    deal_req = 1;
    @(negedge clk);
    deal_req = 0;
    reset_n = 0;
    #1;
    model_reset();
    chk("rst_mid:rnd_req", int'(rnd_req), 0);
    chk("rst_mid:left", int'(cards_left), 52);
    chk("rst_mid:id", int'(card_id), 0);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 4; i++) smp[i] = 6'($urandom_range(0, 63));
      model_deal($sformatf("post%0d", n), 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
